// File: rtl/alu_pkg.sv
// Types and constants shared by the ALU sharing block, the ALU and the bench.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOT = 4'd5,
        ALU_SHL = 4'd6,
        ALU_SHR = 4'd7
    } alu_op_e;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_e;

    // Codes 8..15 are reserved; only the low half of the op space is defined.
    function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
        return ~op[ALU_OP_W-1];
    endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational ALU: eight ops, zero/carry/illegal flags.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]    a_i,
    input  logic [WIDTH-1:0]    b_i,
    input  logic [ALU_OP_W-1:0] op_i,
    output logic [WIDTH-1:0]    result_o,
    output logic                zero_o,
    output logic                carry_o,
    output logic                illegal_o
);

    // Op decode; reserved codes fall through to a zero result.
    always_comb begin
        result_o  = '0;
        carry_o   = 1'b0;
        illegal_o = ~is_legal_op(op_i);
        case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_NOT: result_o = ~a_i;
            ALU_SHL: begin
                result_o = {a_i[WIDTH-2:0], 1'b0};
                carry_o  = a_i[WIDTH-1];
            end
            ALU_SHR: result_o = {1'b0, a_i[WIDTH-1:1]};
            default: result_o = '0;
        endcase
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: scan from ptr upward with wrap, first valid wins.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          advance_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic [IW-1:0] ptr_next_o
);

    // One extra bit so ptr+offset never overflows before the wrap subtract.
    localparam int SW = IW + 1;

    logic          found;
    logic [SW-1:0] sum;
    logic [IW-1:0] idx;

    // Priority scan starting at the pointer; at most one grant bit set.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr_i} + SW'(off);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            idx = sum[IW-1:0];
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

    // Winner becomes lowest priority next time; pointer only moves on accept.
    always_comb begin
        ptr_next_o = ptr_i;
        if (advance_i && found) begin
            ptr_next_o = (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + IW'(1);
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// One ALU shared by NUM_REQ requesters: round-robin pick, 1-cycle result,
// single-entry output register with backpressure.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]    req_op_a,
    input  logic [NUM_REQ*WIDTH-1:0]    req_op_b,
    input  logic [NUM_REQ*ALU_OP_W-1:0] req_alu_op,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [IDW-1:0]              resp_id,
    output logic [WIDTH-1:0]            resp_result,
    output logic                        resp_zero,
    output logic                        resp_carry,
    output logic                        resp_illegal,
    output logic                        busy
);

    arb_state_e state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               can_accept;
    logic               accept;

    logic [WIDTH-1:0]    alu_a, alu_b, alu_res;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_zero, alu_carry, alu_illegal;

    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ill_q, ill_d;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .advance_i   (accept),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .ptr_next_o  (ptr_d)
    );

    // Output slot is free when empty or when its current result leaves this cycle.
    always_comb begin
        resp_valid = (state_q == ARB_FULL);
        can_accept = (state_q == ARB_EMPTY) | (resp_valid & resp_ready);
        req_ready  = grant & {NUM_REQ{can_accept & ~rst}};
        accept     = |req_ready;
        busy       = resp_valid | (|req_valid);
    end

    // Route the granted requester's operands to the single ALU.
    always_comb begin
        alu_a  = req_op_a[int'(grant_idx)*WIDTH +: WIDTH];
        alu_b  = req_op_b[int'(grant_idx)*WIDTH +: WIDTH];
        alu_op = req_alu_op[int'(grant_idx)*ALU_OP_W +: ALU_OP_W];
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .a_i       (alu_a),
        .b_i       (alu_b),
        .op_i      (alu_op),
        .result_o  (alu_res),
        .zero_o    (alu_zero),
        .carry_o   (alu_carry),
        .illegal_o (alu_illegal)
    );

    // Slot FSM next state plus response-register load; everything holds by default.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        res_d   = res_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ill_d   = ill_q;
        case (state_q)
            ARB_EMPTY: if (accept) state_d = ARB_FULL;
            ARB_FULL: begin
                if (accept)          state_d = ARB_FULL;
                else if (resp_ready) state_d = ARB_EMPTY;
            end
            default: state_d = ARB_EMPTY;
        endcase
        if (accept) begin
            id_d    = grant_idx;
            res_d   = alu_res;
            zero_d  = alu_zero;
            carry_d = alu_carry;
            ill_d   = alu_illegal;
        end
    end

    // State, pointer and response register; reset drops any held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_EMPTY;
            ptr_q   <= '0;
            id_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ill_q   <= ill_d;
        end
    end

    assign resp_id      = id_q;
    assign resp_result  = res_q;
    assign resp_zero    = zero_q;
    assign resp_carry   = carry_q;
    assign resp_illegal = ill_q;

    // Handshake sanity: single accept per cycle, response frozen while stalled.
    a_onehot_ready : assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
    a_resp_stable  : assert property (@(posedge clk) disable iff (rst)
        (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_result) && $stable(resp_id)));

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench: accepts push expected entries, a monitor pops on response handshake.
module tb_alu_share_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                           OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_op_a = '0;
    logic [N*W-1:0] req_op_b = '0;
    logic [N*4-1:0] req_alu_op = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b0;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_result;
    logic           resp_zero, resp_carry, resp_illegal, busy;

    alu_share_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_a(req_op_a), .req_op_b(req_op_b), .req_alu_op(req_alu_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_carry(resp_carry),
        .resp_illegal(resp_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        il;
    } exp_t;

    exp_t slot_exp[N];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er,
                         input logic ez, input logic ec, input logic eil);
        req_op_a[i*W +: W]  = a;
        req_op_b[i*W +: W]  = b;
        req_alu_op[i*4 +: 4] = op;
        slot_exp[i] = '{id: i, res: er, z: ez, c: ec, il: eil};
        req_valid[i] = 1'b1;
    endtask

    task automatic await_accept(input int i, input string name);
        bit got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        if (got) begin
            step();
            req_valid[i] = 1'b0;
        end else begin
            n_chk++;
            $display("FAIL %s: req%0d not accepted within 20 cycles", name, i);
            req_valid[i] = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        resp_ready = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !resp_valid) done = 1'b1;
        end
        if (!done) begin
            n_chk++;
            $display("FAIL %s: drain timeout, %0d responses outstanding", name, sb.size());
        end
        step();
    endtask

    // Acceptance watcher: each accept queues the bench's expected response for that slot.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) sb.push_back(slot_exp[i]);
            end
        end
    end

    // Response monitor: compare every handshaken response against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_resp: got id %0d result %h with nothing expected",
                         resp_id, resp_result);
            end else begin
                e = sb.pop_front();
                check("resp_id",      32'(resp_id),      32'(e.id));
                check("resp_result",  resp_result,       e.res);
                check("resp_zero",    32'(resp_zero),    32'(e.z));
                check("resp_carry",   32'(resp_carry),   32'(e.c));
                check("resp_illegal", 32'(resp_illegal), 32'(e.il));
            end
        end
    end

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        il;
    } vec_t;

    vec_t vecs[10];
    int   g_seq[5];

    initial begin
        vecs[0] = '{3, OP_SHL, 32'h8000_0001, 32'h0,         32'h0000_0002, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{0, OP_SUB, 32'd9,         32'd9,         32'h0,         1'b1, 1'b0, 1'b0};
        vecs[2] = '{1, OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{2, OP_OR,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{3, OP_XOR, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{0, OP_NOT, 32'h0000_FFFF, 32'h0,         32'hFFFF_0000, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1, OP_SHR, 32'h8000_0001, 32'h0,         32'h4000_0000, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{2, OP_ADD, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 1'b0};
        vecs[8] = '{2, 4'hC,   32'd5,         32'd6,         32'h0,         1'b1, 1'b0, 1'b1};
        vecs[9] = '{3, OP_SHL, 32'h0000_0001, 32'h0,         32'h0000_0002, 1'b0, 1'b0, 1'b0};
        g_seq   = '{0, 1, 2, 3, 0};

        // Reset: no ready while rst even with every request up, then cleared state.
        req_valid = 4'hF;
        @(negedge clk);
        check("rst_ready_low", 32'(req_ready), 32'h0);
        step();
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_result", resp_result, 32'h0);
        check("rst_flags", 32'({resp_id, resp_zero, resp_carry, resp_illegal}), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        step();

        // 1: reset while a response is held.
        resp_ready = 1'b0;
        drive(0, OP_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0);
        await_accept(0, "t1_accept");
        @(negedge clk);
        check("t1_held_valid", 32'(resp_valid), 32'h1);
        check("t1_held_result", resp_result, 32'd7);
        check("t1_busy", 32'(busy), 32'h1);
        step();
        rst = 1'b1;
        drive(0, OP_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_rst_ready_low", 32'(req_ready), 32'h0);
        step();
        rst = 1'b0;
        sb.delete();
        resp_ready = 1'b1;
        drive(1, OP_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_discarded", 32'(resp_valid), 32'h0);
        check("t1_post_rst_grant", 32'(req_ready), 32'h1);
        step();
        req_valid[0] = 1'b0;
        await_accept(1, "t1_req1");
        drain("t1_drain");

        // 2: round robin with all four requesting, one result per cycle.
        rst = 1'b1;
        step();
        rst = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++)
            drive(i, OP_ADD, 32'(i + 1), 32'd100, 32'(101 + i), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t2_grant", 32'(req_ready), 32'(1 << g_seq[k]));
            if (k > 0) begin
                check("t2_resp_valid", 32'(resp_valid), 32'h1);
                check("t2_resp_id", 32'(resp_id), 32'(g_seq[k-1]));
            end
            step();
            if (k > 0) req_valid[g_seq[k]] = 1'b0;
        end
        drain("t2_drain");

        // 3: backpressure holds the result and blocks all accepts until drain.
        resp_ready = 1'b0;
        drive(1, OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        await_accept(1, "t3_accept");
        drive(0, OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
        drive(3, OP_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_ready_blocked", 32'(req_ready), 32'h0);
            check("t3_valid_held", 32'(resp_valid), 32'h1);
            check("t3_result_stable", resp_result, 32'hFFFF_FFFE);
        end
        step();
        resp_ready = 1'b1;
        @(negedge clk);
        check("t3_drain_and_accept", 32'(req_ready), 32'h8);
        step();
        req_valid[3] = 1'b0;
        await_accept(0, "t3_req0");
        drain("t3_drain");

        // 4/5: flags and illegal op, one request at a time.
        for (int v = 0; v < 10; v++) begin
            drive(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].r,
                  vecs[v].z, vecs[v].c, vecs[v].il);
            await_accept(vecs[v].id, "t4_accept");
        end
        drain("t4_drain");

        // 6: pointer holds across idle cycles after a grant to req2.
        drive(2, OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
        await_accept(2, "t6_req2");
        repeat (5) step();
        drive(0, OP_ADD, 32'd4, 32'd4, 32'd8, 1'b0, 1'b0, 1'b0);
        drive(3, OP_ADD, 32'd5, 32'd5, 32'd10, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_ptr_hold_grant", 32'(req_ready), 32'h8);
        step();
        req_valid[3] = 1'b0;
        await_accept(0, "t6_req0");
        drain("t6_drain");

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
